ne_llr_frame_packer: RTL and testbench
======================================

# ne_llr_frame_packer

Upstream feeder for the decoder top's input interface. Accepts one channel LLR per cycle over a valid/ready handshake, saturates it to the decoder's W-bit format, packs 32 LLRs per word into the DW-bit `Codeword_in` bus and pulses `code_valid` once per completed word. Words are emitted frame by frame: 8176 LLRs (16 circulant columns × 511) per frame, with the final partial word padded. Runs entirely in the decoder's input clock domain.

## Interface
- `W`, 6, decoder LLR width (two's complement)
- `IW`, 8, incoming channel LLR width (two's complement, IW ≥ W)
- `MAXVAL`, 31, symmetric saturation magnitude; must be ≤ 2^(W-1)-1
- `FRAMELEN`, 8176, LLRs per frame
- `PADVAL`, 0, W-bit value written into unused lanes of the last word
- `DW`, 32*W, derived, output word width (not to be overridden)

Ports:
- `inclk`  in  1  clock; one clock only
- `rst`  in  1  synchronous, active-high reset
- `llr_in`  in  IW  signed channel LLR
- `llr_valid`  in  1  `llr_in` valid
- `llr_ready`  out  1  packer accepts `llr_in` this cycle
- `frame_en`  in  1  level; downstream permits a new frame to start
- `Codeword_in`  out  DW  packed word; lane k at bits [k*W +: W], lane 0 = first-accepted LLR
- `code_valid`  out  1  one-cycle pulse, `Codeword_in` valid
- `frame_done`  out  1  one-cycle pulse coincident with the last word's `code_valid`
- `sat_count`  out  16  LLRs saturated in the most recent frame

## Operation
- States: IDLE, FILL.
- IDLE: `llr_ready`=0. If `frame_en`=1 → FILL next cycle; `sat_count` and lane/LLR counters cleared on that transition.
- FILL: `llr_ready`=1. Transfer = `llr_valid` & `llr_ready`. Each transfer writes the saturated LLR into lane `lane_cnt` and increments `lane_cnt` (5 bits, wraps 31→0) and `llr_cnt` (0..FRAMELEN-1).
- Word completion: transfer with `lane_cnt`=31, or transfer with `llr_cnt`=FRAMELEN-1. On the following cycle `Codeword_in` holds the word and `code_valid`=1.
- Last word: lanes above the final lane forced to PADVAL; with defaults, 8176 mod 32 = 16, so lanes 16..31 = PADVAL; 256 words per frame. `frame_done`=1 with it; state → IDLE the same cycle as the last transfer.
- `frame_en` is sampled only in IDLE; deassertion mid-frame has no effect. Minimum one IDLE cycle between frames.
- `llr_valid` low in FILL: stall, no state change, no partial word emitted.
- Saturation: llr_in > MAXVAL → MAXVAL; llr_in < -MAXVAL → -MAXVAL (so −2^(W-1) is never produced); otherwise truncated to W bits. Each clamped transfer increments `sat_count`, which holds at 16'hFFFF.
- Reset (any time, including mid-frame): state IDLE; `llr_ready`, `code_valid`, `frame_done`=0; `Codeword_in`, `sat_count`, counters=0. A partially filled word is discarded and never emitted.

## Timing
- Latency: last LLR of a word accepted at cycle t → `code_valid` at t+1.
- Throughput: one LLR per cycle; one word per 32 cycles at full rate; frame = FRAMELEN transfer cycles + 1 IDLE cycle minimum.
- `Codeword_in` is registered and holds its value until the next word; its content is not guaranteed meaningful when `code_valid`=0.
- `code_valid` is never high on two consecutive cycles.
- `llr_ready` is registered (state-derived); no combinational path from `llr_valid` to `llr_ready`.
- `sat_count` is final from the `frame_done` cycle until the next IDLE→FILL transition.

## Structure
- Package `ne_packer_pkg`: state enum (IDLE, FILL), LANES=32, LANEBITS=5, FRAMELEN default, WORDS=ceil(FRAMELEN/32) constant, `sat_count` width.
- One combinational sub-module `ne_llr_saturate` (IW→W clamp, outputs saturated value plus `clamped` flag); the packer contains the FSM, counters, lane register file and output register.

## Test plan
- Reset, then frame_en=1, 8176 LLRs with llr_in=k mod 32 and valid held high → 256 `code_valid` pulses 32 cycles apart; each full word has lane k = k; word 255 has lanes 0..15 = 0..15 and lanes 16..31 = 0; `frame_done` only with word 255.
- Saturation: llr_in = +100, −100, −32, +31, −31 → lanes +31, −31, −31, +31, −31; after the frame `sat_count`=3.
- Random `llr_valid` gaps (≈50 %) → identical word sequence to the gap-free run; `code_valid` exactly one cycle after each 32nd transfer.
- `rst` asserted after 40 transfers → next cycle all outputs 0, only word 0 was ever emitted; a new frame then starts cleanly at lane 0.
- frame_en dropped mid-frame and held low after the end → frame still completes with 256 words; packer stays in IDLE with `llr_ready`=0 until frame_en=1; frame_en held high → next frame starts after exactly one IDLE cycle.

Source files
------------

// File: rtl/ne_packer_pkg.sv
// Shared constants and types for the LLR frame packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, lane geometry, default frame length, word count, sat counter width.
package ne_packer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam int LANES        = 32;
  localparam int LANEBITS     = 5;
  localparam int FRAMELEN_DEF = 8176;
  localparam int SATW         = 16;

  // Words per frame; the last one is partially filled when FRAMELEN is not a multiple of LANES.
  function automatic int words_for(input int framelen);
    return (framelen + LANES - 1) / LANES;
  endfunction

  localparam int WORDS = (FRAMELEN_DEF + LANES - 1) / LANES;

endpackage

// File: rtl/ne_llr_saturate.sv
// Symmetric clamp of an IW-bit signed channel LLR to the decoder's W-bit format.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
// Ports: i_llr (IW, signed in), o_llr (W, clamped out), o_clamped (1 when the value was limited).
module ne_llr_saturate #(
  parameter int W      = 6,
  parameter int IW     = 8,
  parameter int MAXVAL = 31
) (
  input  logic [IW-1:0] i_llr,
  output logic [W-1:0]  o_llr,
  output logic          o_clamped
);

  logic signed [IW-1:0] w_in;
  logic signed [IW-1:0] w_pos;
  logic signed [IW-1:0] w_neg;

  assign w_in  = $signed(i_llr);
  assign w_pos = IW'(MAXVAL);
  // Negative bound is -MAXVAL, not -(MAXVAL+1), so the most negative W-bit code never appears.
  assign w_neg = -w_pos;

  always_comb begin
    o_llr     = w_in[W-1:0];
    o_clamped = 1'b0;
    if (w_in > w_pos) begin
      o_llr     = w_pos[W-1:0];
      o_clamped = 1'b1;
    end else if (w_in < w_neg) begin
      o_llr     = w_neg[W-1:0];
      o_clamped = 1'b1;
    end
  end

endmodule

// File: rtl/ne_llr_frame_packer.sv
// Packs saturated channel LLRs 32 per word into Codeword_in, frame by frame, padding the last word.
// Latency: word registered one cycle after the transfer that completes it (code_valid pulse).
// Backpressure: llr_ready is state-derived (high only in FILL); frame_en gates frame start in IDLE.
// Ports: inclk/rst (sync, active high); llr_in/llr_valid/llr_ready input handshake; frame_en level;
//        Codeword_in/code_valid/frame_done output word and pulses; sat_count clamps in last frame.
module ne_llr_frame_packer
  import ne_packer_pkg::*;
#(
  parameter int             W        = 6,
  parameter int             IW       = 8,
  parameter int             MAXVAL   = 31,
  parameter int             FRAMELEN = FRAMELEN_DEF,
  parameter logic [W-1:0]   PADVAL   = '0,
  localparam int            DW       = LANES * W
) (
  input  logic            inclk,
  input  logic            rst,
  input  logic [IW-1:0]   llr_in,
  input  logic            llr_valid,
  output logic            llr_ready,
  input  logic            frame_en,
  output logic [DW-1:0]   Codeword_in,
  output logic            code_valid,
  output logic            frame_done,
  output logic [SATW-1:0] sat_count
);

  localparam int CNTW = $clog2(FRAMELEN);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_start;
  logic [LANEBITS-1:0] r_lane_cnt;
  logic [CNTW-1:0]     r_llr_cnt;
  logic [W-1:0]        r_lanes [LANES];
  logic [DW-1:0]       r_word;
  logic [DW-1:0]       w_word;
  logic                r_code_valid;
  logic                r_frame_done;
  logic [SATW-1:0]     r_sat_count;
  logic [W-1:0]        w_sat;
  logic                w_clamped;
  logic                w_xfer;
  logic                w_last;
  logic                w_word_done;

  ne_llr_saturate #(
    .W      (W),
    .IW     (IW),
    .MAXVAL (MAXVAL)
  ) u_sat (
    .i_llr     (llr_in),
    .o_llr     (w_sat),
    .o_clamped (w_clamped)
  );

  assign llr_ready   = (r_state == FILL);
  assign w_xfer      = llr_valid & llr_ready;
  assign w_last      = (r_llr_cnt == CNTW'(FRAMELEN - 1));
  assign w_word_done = w_xfer & ((r_lane_cnt == LANEBITS'(LANES - 1)) | w_last);

  always_ff @(posedge inclk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_en) begin
          w_state_nxt = FILL;
          w_start     = 1'b1;
        end
      end
      FILL: begin
        if (w_xfer && w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outgoing word: lanes already written, the lane arriving this cycle, and PADVAL above it.
  // For full words the arriving lane is 31, so no padding applies.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < LANES; k++) begin
      if (LANEBITS'(k) < r_lane_cnt) begin
        w_word[k*W +: W] = r_lanes[k];
      end else if (LANEBITS'(k) == r_lane_cnt) begin
        w_word[k*W +: W] = w_sat;
      end else begin
        w_word[k*W +: W] = PADVAL;
      end
    end
  end

  // Lane storage needs no reset: only lanes written earlier in the current word are ever read.
  always_ff @(posedge inclk) begin
    if (w_xfer) begin
      r_lanes[r_lane_cnt] <= w_sat;
    end
  end

  always_ff @(posedge inclk) begin
    if (rst) begin
      r_lane_cnt   <= '0;
      r_llr_cnt    <= '0;
      r_word       <= '0;
      r_code_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_sat_count  <= '0;
    end else begin
      r_code_valid <= w_word_done;
      r_frame_done <= w_word_done & w_last;
      if (w_word_done) begin
        r_word <= w_word;
      end
      if (w_start) begin
        r_lane_cnt  <= '0;
        r_llr_cnt   <= '0;
        r_sat_count <= '0;
      end else if (w_xfer) begin
        r_lane_cnt <= r_lane_cnt + 1'b1;
        r_llr_cnt  <= w_last ? '0 : r_llr_cnt + 1'b1;
        if (w_clamped && (r_sat_count != '1)) begin
          r_sat_count <= r_sat_count + 1'b1;
        end
      end
    end
  end

  assign Codeword_in = r_word;
  assign code_valid  = r_code_valid;
  assign frame_done  = r_frame_done;
  assign sat_count   = r_sat_count;

endmodule

// File: tb/tb_ne_llr_frame_packer.sv
// Self-checking bench for ne_llr_frame_packer: directed frames, saturation table, gaps, reset, frame_en.
// Latency: checks code_valid exactly one cycle after each word-completing transfer.
// Backpressure: drives llr_valid with and without gaps; waits on llr_ready with bounded retries.
module tb_ne_llr_frame_packer;
  import ne_packer_pkg::*;

  localparam int W  = 6;
  localparam int IW = 8;
  localparam int FL = 8176;
  localparam int NW = 256;
  localparam int DW = 32 * W;
  localparam int NV = 12;

  logic            inclk = 1'b0;
  logic            rst;
  logic [IW-1:0]   llr_in;
  logic            llr_valid;
  logic            llr_ready;
  logic            frame_en;
  logic [DW-1:0]   Codeword_in;
  logic            code_valid;
  logic            frame_done;
  logic [SATW-1:0] sat_count;

  ne_llr_frame_packer dut (
    .inclk       (inclk),
    .rst         (rst),
    .llr_in      (llr_in),
    .llr_valid   (llr_valid),
    .llr_ready   (llr_ready),
    .frame_en    (frame_en),
    .Codeword_in (Codeword_in),
    .code_valid  (code_valid),
    .frame_done  (frame_done),
    .sat_count   (sat_count)
  );

  always #5 inclk = ~inclk;

  typedef struct {
    logic [7:0] inp;
    logic [5:0] exp;
    int         clamp;
  } sat_vec_t;

  sat_vec_t tab [NV];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fx = 0;
  int last_xfer_cyc = -10;
  int fd_any = 0;
  int fd_cv = 0;
  bit prev_cv = 1'b0;
  bit abort = 1'b0;
  logic [DW-1:0] obs [$];

  always @(posedge inclk) cyc <= cyc + 1;

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] llr_val(input int mode, input int idx);
    if (mode == 1 && idx < NV) return tab[idx].inp;
    return 8'(idx % 32);
  endfunction

  function automatic logic [5:0] exp_lane(input int mode, input int idx);
    if (mode == 1 && idx < NV) return tab[idx].exp;
    return 6'(idx % 32);
  endfunction

  function automatic logic [DW-1:0] exp_word(input int mode, input int w);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) begin
      if (w * 32 + k < FL) r[k*W +: W] = exp_lane(mode, w * 32 + k);
      else                 r[k*W +: W] = 6'd0;
    end
    return r;
  endfunction

  // Word monitor: latency, boundary, frame_done coincidence and pulse spacing.
  always @(negedge inclk) begin
    if (frame_done) fd_any++;
    if (code_valid) begin
      chk_i("cv_latency", cyc - last_xfer_cyc, 1);
      chk_i("cv_boundary", int'((fx % 32 == 0) || (fx == FL)), 1);
      chk_i("frame_done_pos", int'(frame_done), int'(fx == FL));
      chk_i("cv_back_to_back", int'(prev_cv), 0);
      obs.push_back(Codeword_in);
      if (frame_done) fd_cv++;
    end
    prev_cv = code_valid;
    if (llr_valid && llr_ready) begin
      fx++;
      last_xfer_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge inclk);
    #1;
  endtask

  task automatic run_frame(input int mode, input bit gaps, input int drop_at, input int nsend);
    int  tries;
    bit  acc;
    bit  done;
    fx     = 0;
    fd_any = 0;
    fd_cv  = 0;
    obs.delete();
    for (int i = 0; i < nsend && !abort; i++) begin
      if (i == drop_at) frame_en = 1'b0;
      llr_in = llr_val(mode, i);
      tries  = 0;
      done   = 1'b0;
      while (!done) begin
        llr_valid = gaps ? ($urandom_range(1) == 1) : 1'b1;
        acc = llr_valid && llr_ready;
        step();
        if (acc) begin
          done = 1'b1;
        end else begin
          tries++;
          if (tries > 200) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: LLR %0d not accepted in 200 cycles, llr_ready=%0b", i, llr_ready);
            abort = 1'b1;
            done  = 1'b1;
          end
        end
      end
    end
    llr_valid = 1'b0;
  endtask

  task automatic check_frame(input int mode, input string tag);
    chk_i({tag, "_word_count"}, obs.size(), NW);
    for (int i = 0; i < obs.size() && i < NW; i++) begin
      chk_w($sformatf("%s_word%0d", tag, i), obs[i], exp_word(mode, i));
    end
    chk_i({tag, "_frame_done_pulses"}, fd_any, 1);
    chk_i({tag, "_frame_done_with_cv"}, fd_cv, 1);
  endtask

  initial begin
    logic [DW-1:0] w0;
    int            exp_sat;

    tab[0]  = '{8'd100, 6'h1F, 1};
    tab[1]  = '{8'h9C,  6'h21, 1};
    tab[2]  = '{8'hE0,  6'h21, 1};
    tab[3]  = '{8'd31,  6'h1F, 0};
    tab[4]  = '{8'hE1,  6'h21, 0};
    tab[5]  = '{8'd127, 6'h1F, 1};
    tab[6]  = '{8'h80,  6'h21, 1};
    tab[7]  = '{8'd32,  6'h1F, 1};
    tab[8]  = '{8'hFF,  6'h3F, 0};
    tab[9]  = '{8'd5,   6'h05, 0};
    tab[10] = '{8'hDF,  6'h21, 1};
    tab[11] = '{8'd0,   6'h00, 0};

    rst       = 1'b1;
    frame_en  = 1'b0;
    llr_valid = 1'b0;
    llr_in    = '0;
    repeat (3) step();
    chk_i("rst_ready", int'(llr_ready), 0);
    chk_i("rst_code_valid", int'(code_valid), 0);
    chk_i("rst_frame_done", int'(frame_done), 0);
    chk_i("rst_sat_count", int'(sat_count), 0);
    chk_w("rst_codeword", Codeword_in, '0);

    // Frame A: ramp 0..31, no gaps, frame_en held high.
    rst      = 1'b0;
    frame_en = 1'b1;
    run_frame(0, 1'b0, -1, FL);
    chk_i("A_idle_after_last", int'(llr_ready), 0);
    chk_i("A_sat_count", int'(sat_count), 0);
    step();
    chk_i("A_restart_after_one_idle", int'(llr_ready), 1);
    check_frame(0, "A");

    // Frame B: saturation table at the head of the frame.
    run_frame(1, 1'b0, -1, FL);
    exp_sat = 0;
    for (int j = 0; j < NV; j++) exp_sat += tab[j].clamp;
    chk_i("B_sat_count", int'(sat_count), exp_sat);
    step();
    w0 = (obs.size() > 0) ? obs[0] : '0;
    for (int j = 0; j < NV; j++) begin
      chk_i($sformatf("B_sat_lane%0d", j), int'(w0[j*W +: W]), int'(tab[j].exp));
    end
    check_frame(1, "B");

    // Frame C: about half of the cycles without llr_valid.
    run_frame(0, 1'b1, -1, FL);
    step();
    check_frame(0, "C");

    // Reset after 40 transfers: word 0 emitted, partial word 1 discarded.
    run_frame(0, 1'b0, -1, 40);
    frame_en = 1'b0;
    rst      = 1'b1;
    step();
    chk_i("mid_rst_ready", int'(llr_ready), 0);
    chk_i("mid_rst_code_valid", int'(code_valid), 0);
    chk_i("mid_rst_frame_done", int'(frame_done), 0);
    chk_i("mid_rst_sat_count", int'(sat_count), 0);
    chk_w("mid_rst_codeword", Codeword_in, '0);
    rst = 1'b0;
    repeat (3) step();
    chk_i("mid_rst_stays_idle", int'(llr_ready), 0);
    chk_i("mid_rst_word_count", obs.size(), 1);
    chk_w("mid_rst_word0", (obs.size() > 0) ? obs[0] : '0, exp_word(0, 0));

    // Frame D: fresh start at lane 0, frame_en dropped after 100 transfers.
    frame_en = 1'b1;
    run_frame(0, 1'b0, 100, FL);
    for (int j = 0; j < 10; j++) begin
      chk_i($sformatf("D_idle_hold%0d", j), int'(llr_ready), 0);
      step();
    end
    check_frame(0, "D");
    frame_en = 1'b1;
    step();
    chk_i("D_restart", int'(llr_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
